// File: rtl/mem_align_unit.sv
// Data-side access sequencer in front of the BRAM data port: passes aligned
// accesses straight through and splits word-crossing loads/stores into aligned pieces.
module mem_align_unit #(
  parameter logic [31:0] IO_BASE = 32'h11000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  output logic        STALL,
  output logic        RESP_VALID,
  output logic [31:0] RESP_RDATA,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, ST_SEQ, LD_HI, LD_WAIT} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ld_pend;
  logic [31:0]     r_lo;

  logic [1:0]      w_off;
  logic            w_misaligned;
  logic            w_split;
  logic [AW-1:0]   w_base;
  logic [CW-1:0]   w_last_cnt;
  logic            w_last;
  logic [7:0]      w_wbyte;
  logic [63:0]     w_pair;
  logic [31:0]     w_word;
  logic [31:0]     w_ext;

  // Split decision: only cacheable space, only accesses that leave their word
  assign w_off        = REQ_ADDR[1:0];
  assign w_misaligned = ((REQ_SIZE == 2'd1) && (w_off == 2'd3)) ||
                        ((REQ_SIZE == 2'd2) && (w_off != 2'd0));
  assign w_split      = REQ_VALID && (REQ_ADDR < IO_BASE) && w_misaligned;
  assign w_base       = {REQ_ADDR[31:2], 2'b00};

  assign w_last_cnt   = (REQ_SIZE == 2'd1) ? CW'(1) : CW'(3);
  assign w_last       = (r_cnt == w_last_cnt);
  assign w_wbyte      = 8'(REQ_WDATA >> {r_cnt, 3'b000});

  // Merge low word (held) with high word (arriving now) and shift the access down
  assign w_pair       = {MEM_DOUT2, r_lo};
  assign w_word       = 32'(w_pair >> {w_off, 3'b000});
  assign w_ext        = (REQ_SIZE == 2'd1) ?
                        (REQ_SIGN ? {16'h0000, w_word[15:0]}
                                  : {{16{w_word[15]}}, w_word[15:0]}) :
                        w_word;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ld_pend <= 1'b0;
      r_lo      <= '0;
    end else begin
      r_ld_pend <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_split) begin
            if (REQ_WE) begin
              r_cnt   <= CW'(1);
              r_state <= ST_SEQ;
            end else begin
              r_state <= LD_HI;
            end
          end else begin
            r_ld_pend <= REQ_VALID && !REQ_WE;
          end
        end
        ST_SEQ: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        LD_HI: begin
          r_lo    <= MEM_DOUT2;
          r_state <= LD_WAIT;
        end
        LD_WAIT: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Port drive: pass-through by default, overridden while sequencing
  always_comb begin
    MEM_ADDR2  = REQ_ADDR;
    MEM_DIN2   = REQ_WDATA;
    MEM_WRITE2 = REQ_VALID && REQ_WE;
    MEM_READ2  = REQ_VALID && !REQ_WE;
    MEM_SIZE   = REQ_SIZE;
    MEM_SIGN   = REQ_SIGN;
    STALL      = 1'b0;
    RESP_VALID = r_ld_pend;
    RESP_RDATA = MEM_DOUT2;

    case (r_state)
      IDLE: begin
        if (w_split) begin
          STALL    = 1'b1;
          MEM_SIGN = 1'b0;
          if (REQ_WE) begin
            MEM_DIN2   = {24'h000000, REQ_WDATA[7:0]};
            MEM_SIZE   = 2'd0;
            MEM_WRITE2 = 1'b1;
            MEM_READ2  = 1'b0;
          end else begin
            MEM_ADDR2  = w_base;
            MEM_SIZE   = 2'd2;
            MEM_WRITE2 = 1'b0;
            MEM_READ2  = 1'b1;
          end
        end
      end
      ST_SEQ: begin
        MEM_ADDR2  = REQ_ADDR + AW'(r_cnt);
        MEM_DIN2   = {24'h000000, w_wbyte};
        MEM_SIZE   = 2'd0;
        MEM_SIGN   = 1'b0;
        MEM_WRITE2 = 1'b1;
        MEM_READ2  = 1'b0;
        STALL      = !w_last;
      end
      LD_HI: begin
        MEM_ADDR2  = w_base + AW'(4);
        MEM_SIZE   = 2'd2;
        MEM_SIGN   = 1'b0;
        MEM_WRITE2 = 1'b0;
        MEM_READ2  = 1'b1;
        STALL      = 1'b1;
      end
      LD_WAIT: begin
        MEM_WRITE2 = 1'b0;
        MEM_READ2  = 1'b0;
        STALL      = 1'b0;
        RESP_VALID = 1'b1;
        RESP_RDATA = w_ext;
      end
      default: ;
    endcase

    // Reset silences every strobe regardless of state
    if (RST) begin
      STALL      = 1'b0;
      RESP_VALID = 1'b0;
      MEM_WRITE2 = 1'b0;
      MEM_READ2  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit with a small byte-addressed BRAM model on port 2.
module tb_mem_align_unit;

  localparam logic [31:0] IO_BASE = 32'h11000000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGN;
  logic        STALL;
  logic        RESP_VALID;
  logic [31:0] RESP_RDATA;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_WRITE2;
  logic        MEM_READ2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mem [0:4095];
  logic [31:0] r_dout = 32'h0;

  mem_align_unit #(.IO_BASE(IO_BASE)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_SIZE(REQ_SIZE), .REQ_SIGN(REQ_SIGN),
    .STALL(STALL), .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
    .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] bram_rd(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [11:0] i;
    logic [31:0] w;
    i = a[11:0];
    w = {mem[i + 12'd3], mem[i + 12'd2], mem[i + 12'd1], mem[i]};
    case (sz)
      2'd0:    return sg ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'd1:    return sg ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // BRAM port 2: byte-lane writes, registered read data
  always @(posedge CLK) begin
    if (MEM_WRITE2 && (MEM_ADDR2 < IO_BASE)) begin
      mem[MEM_ADDR2[11:0]] <= MEM_DIN2[7:0];
      if (MEM_SIZE != 2'd0) mem[MEM_ADDR2[11:0] + 12'd1] <= MEM_DIN2[15:8];
      if (MEM_SIZE == 2'd2) begin
        mem[MEM_ADDR2[11:0] + 12'd2] <= MEM_DIN2[23:16];
        mem[MEM_ADDR2[11:0] + 12'd3] <= MEM_DIN2[31:24];
      end
    end
    if (MEM_READ2) r_dout <= bram_rd(MEM_ADDR2, MEM_SIZE, MEM_SIGN);
  end
  assign MEM_DOUT2 = r_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic sg);
    REQ_VALID = v;
    REQ_WE    = we;
    REQ_ADDR  = a;
    REQ_WDATA = wd;
    REQ_SIZE  = sz;
    REQ_SIGN  = sg;
  endtask

  task automatic idle_req();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic store_pt(input logic [31:0] a, input logic [31:0] d);
    set_req(1'b1, 1'b1, a, d, 2'd2, 1'b0);
    @(negedge CLK);
    chk("pt_st_stall", 32'(STALL), 32'd0);
    tick();
    idle_req();
  endtask

  task automatic load_pt(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] exp);
    set_req(1'b1, 1'b0, a, 32'h0, sz, sg);
    @(negedge CLK);
    chk({tag, "_stall"}, 32'(STALL), 32'd0);
    chk({tag, "_read2"}, 32'(MEM_READ2), 32'd1);
    tick();
    idle_req();
    @(negedge CLK);
    chk({tag, "_rvalid"}, 32'(RESP_VALID), 32'd1);
    chk({tag, "_rdata"}, RESP_RDATA, exp);
    tick();
  endtask

  task automatic split_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic sg, input logic [31:0] exp);
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    set_req(1'b1, 1'b0, a, 32'h0, sz, sg);
    @(negedge CLK);
    chk({tag, "_c1_stall"}, 32'(STALL), 32'd1);
    chk({tag, "_c1_addr"}, MEM_ADDR2, base);
    chk({tag, "_c1_read"}, {29'd0, MEM_READ2, MEM_SIZE}, {29'd0, 1'b1, 2'd2});
    chk({tag, "_c1_rvalid"}, 32'(RESP_VALID), 32'd0);
    tick();
    @(negedge CLK);
    chk({tag, "_c2_stall"}, 32'(STALL), 32'd1);
    chk({tag, "_c2_addr"}, MEM_ADDR2, base + 32'd4);
    chk({tag, "_c2_read"}, 32'(MEM_READ2), 32'd1);
    tick();
    @(negedge CLK);
    chk({tag, "_c3_stall"}, 32'(STALL), 32'd0);
    chk({tag, "_c3_strobes"}, {30'd0, MEM_READ2, MEM_WRITE2}, 32'd0);
    chk({tag, "_c3_rvalid"}, 32'(RESP_VALID), 32'd1);
    chk({tag, "_c3_rdata"}, RESP_RDATA, exp);
    tick();
  endtask

  task automatic split_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz);
    int n;
    logic [31:0] sh;
    n = (sz == 2'd1) ? 2 : 4;
    set_req(1'b1, 1'b1, a, d, sz, 1'b0);
    for (int k = 0; k < n; k++) begin
      sh = d >> (8 * k);
      @(negedge CLK);
      chk({tag, "_stall"}, 32'(STALL), (k < n - 1) ? 32'd1 : 32'd0);
      chk({tag, "_write"}, {29'd0, MEM_WRITE2, MEM_SIZE}, {29'd0, 1'b1, 2'd0});
      chk({tag, "_addr"}, MEM_ADDR2, a + 32'(k));
      chk({tag, "_byte"}, {24'd0, MEM_DIN2[7:0]}, {24'd0, sh[7:0]});
      tick();
    end
    idle_req();
  endtask

  initial begin
    RST = 1'b1;
    set_req(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    tick();
    @(negedge CLK);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_rvalid", 32'(RESP_VALID), 32'd0);
    chk("rst_strobes", {30'd0, MEM_READ2, MEM_WRITE2}, 32'd0);
    tick();
    RST = 1'b0;
    idle_req();
    @(negedge CLK);
    chk("post_rst_rvalid", 32'(RESP_VALID), 32'd0);
    tick();

    // aligned pass-through
    store_pt(32'h100, 32'h12345678);
    load_pt("lw100", 32'h100, 2'd2, 1'b0, 32'h12345678);

    // crossing sw, then confirm bytes with aligned loads
    store_pt(32'h104, 32'h00000000);
    split_store("sw101", 32'h101, 32'hAABBCCDD, 2'd2);
    load_pt("lw100_after_sw", 32'h100, 2'd2, 1'b0, 32'hBBCCDD78);
    load_pt("lw104_after_sw", 32'h104, 2'd2, 1'b0, 32'h000000AA);

    // crossing lh/lhu back-to-back
    store_pt(32'h100, 32'h34000000);
    store_pt(32'h104, 32'h00000092);
    split_load("lh103", 32'h103, 2'd1, 1'b0, 32'hFFFF9234);
    split_load("lhu103", 32'h103, 2'd1, 1'b1, 32'h00009234);
    idle_req();

    // crossing lw
    store_pt(32'h100, 32'h11223344);
    store_pt(32'h104, 32'h55667788);
    split_load("lw102", 32'h102, 2'd2, 1'b0, 32'h77881122);
    idle_req();

    // crossing sh, then in-word lh at offset 2 passes through
    split_store("sh103", 32'h103, 32'h0000BEEF, 2'd1);
    load_pt("lw100_after_sh", 32'h100, 2'd2, 1'b0, 32'hEF223344);
    load_pt("lw104_after_sh", 32'h104, 2'd2, 1'b0, 32'h556677BE);
    load_pt("lh102_inword", 32'h102, 2'd1, 1'b0, 32'hFFFFEF22);

    // MMIO: misaligned but never split
    set_req(1'b1, 1'b1, 32'h11000001, 32'hCAFEF00D, 2'd2, 1'b0);
    @(negedge CLK);
    chk("mmio_sw_stall", 32'(STALL), 32'd0);
    chk("mmio_sw_write", 32'(MEM_WRITE2), 32'd1);
    chk("mmio_sw_addr", MEM_ADDR2, 32'h11000001);
    chk("mmio_sw_din", MEM_DIN2, 32'hCAFEF00D);
    tick();
    set_req(1'b1, 1'b0, 32'h11000002, 32'h0, 2'd2, 1'b0);
    @(negedge CLK);
    chk("mmio_lw_stall", 32'(STALL), 32'd0);
    chk("mmio_lw_read", 32'(MEM_READ2), 32'd1);
    chk("mmio_lw_addr", MEM_ADDR2, 32'h11000002);
    tick();
    idle_req();
    tick();

    // reset in the second cycle of a split sw
    store_pt(32'h100, 32'h00000000);
    store_pt(32'h104, 32'h00000000);
    set_req(1'b1, 1'b1, 32'h101, 32'hAABBCCDD, 2'd2, 1'b0);
    @(negedge CLK);
    chk("rstsw_c1_addr", MEM_ADDR2, 32'h101);
    chk("rstsw_c1_stall", 32'(STALL), 32'd1);
    tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("rstsw_c2_strobes", {30'd0, MEM_READ2, MEM_WRITE2}, 32'd0);
    chk("rstsw_c2_stall", 32'(STALL), 32'd0);
    tick();
    RST = 1'b0;
    idle_req();
    @(negedge CLK);
    chk("rstsw_after_stall", 32'(STALL), 32'd0);
    chk("rstsw_after_strobes", {30'd0, MEM_READ2, MEM_WRITE2}, 32'd0);
    tick();
    load_pt("rstsw_lw100", 32'h100, 2'd2, 1'b0, 32'h0000DD00);
    load_pt("rstsw_lw104", 32'h104, 2'd2, 1'b0, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
